trigger_qualifier: RTL and testbench

Conditions the combined trigger produced by the ChipWhisperer IO/trigger routing block (`trigger_o`) before it reaches the capture system. It does the following:
- synchronises the trigger;
- selects an edge or level condition;
- rejects pulses shorter than a programmable minimum width;
- enforces arm, one-shot and hold-off rules;
- emits a single-cycle qualified trigger pulse and counts fired triggers.

It is configured over the standard register bus.

---
 rtl/trigger_qualifier_pkg.sv | 37 +++
 rtl/trigqual_defines.sv | 11 +
 rtl/trigqual_sync.sv | 18 +
 rtl/trigger_qualifier.sv | 193 +++++++++++++++++++
 tb/tb_trigger_qualifier.sv | 304 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/trigger_qualifier_pkg.sv
// Shared types and constants for the trigger qualifier: FSM states, trigger
// modes, CFG register bit positions and a register byte-lane helper.
package trigger_qualifier_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARMED   = 3'd1,
    ST_QUAL    = 3'd2,
    ST_FIRE    = 3'd3,
    ST_HOLDOFF = 3'd4
  } tq_state_e;

  typedef enum logic [1:0] {
    MODE_RISE = 2'b00,
    MODE_FALL = 2'b01,
    MODE_HIGH = 2'b10,
    MODE_LOW  = 2'b11
  } tq_mode_e;

  localparam int CFG_MODE_LSB    = 0;
  localparam int CFG_MODE_MSB    = 1;
  localparam int CFG_ONESHOT_BIT = 2;
  localparam int CFG_ARM_BIT     = 3;
  localparam int CFG_DISARM_BIT  = 4;

  localparam int TQ_REG_BYTES = 2;
  localparam int TQ_REG_W     = 8 * TQ_REG_BYTES;

  // Byte lane of a multi-byte register; indices past the top lane read 0.
  function automatic logic [7:0] byte_sel(input logic [TQ_REG_W-1:0] v, input int idx);
    byte_sel = 8'h00;
    for (int b = 0; b < TQ_REG_BYTES; b++) begin
      if (idx == b) byte_sel = v[b*8 +: 8];
    end
  endfunction

endpackage

// File: rtl/trigqual_defines.sv
// Register address map for the trigger qualifier; shares the address space
// with the other capture-path register macros.
`ifndef TRIGQUAL_DEFINES_SV
`define TRIGQUAL_DEFINES_SV

`define TRIGQUAL_CFG_ADDR     8'h50
`define TRIGQUAL_WIDTH_ADDR   8'h51
`define TRIGQUAL_HOLDOFF_ADDR 8'h52
`define TRIGQUAL_COUNT_ADDR   8'h53

`endif

// File: rtl/trigqual_sync.sv
// Two-flop synchroniser with asynchronous active-low clear.
module trigqual_sync (
  input  logic clk_usb,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic [1:0] sync_reg;

  always_ff @(posedge clk_usb or negedge reset_n) begin
    if (!reset_n) sync_reg <= 2'b00;
    else          sync_reg <= {sync_reg[0], d};
  end

  assign q = sync_reg[1];

endmodule

// File: rtl/trigger_qualifier.sv
// Trigger qualifier: sync, edge/level select, min-width filter, arm/one-shot/hold-off.
// Define TRIGQUAL_COUNTER_EN to build the fired-event counter and its register.
`include "trigqual_defines.sv"

module trigger_qualifier
  import trigger_qualifier_pkg::*;
#(
  parameter int pBYTECNT_SIZE = 7,
  parameter int pCNT_WIDTH    = 16
) (
  input  logic                     clk_usb,
  input  logic                     reset_n,
  input  logic [7:0]               reg_address,
  input  logic [pBYTECNT_SIZE-1:0] reg_bytecnt,
  input  logic [7:0]               reg_datai,
  output logic [7:0]               reg_datao,
  input  logic                     reg_read,
  input  logic                     reg_write,
  input  logic                     trigger_i,
  input  logic                     arm_i,
  output logic                     trig_pulse_o,
  output logic                     armed_o,
  output logic                     busy_o
);

  localparam logic [pCNT_WIDTH-1:0] CNT_ONE = {{(pCNT_WIDTH-1){1'b0}}, 1'b1};

  tq_state_e             state_reg, state_next;
  tq_mode_e              mode_reg;
  logic                  oneshot_reg;
  logic [pCNT_WIDTH-1:0] width_reg, holdoff_reg;
  logic [pCNT_WIDTH-1:0] cnt_reg, cnt_next, lim_reg, lim_next;
  logic [pCNT_WIDTH:0]   cnt_inc;
  logic                  ts, ts_d_reg;
  logic                  trig_pulse_reg, armed_reg, busy_reg;

  logic cfg_sel, width_sel, holdoff_sel, count_sel;
  logic cfg_wr, arm_wr, disarm_wr, mode_chg;
  logic active, start, fire_take;
  logic [TQ_REG_BYTES-1:0] width_be, holdoff_be;
  logic [TQ_REG_W-1:0]     width_cur, width_new, holdoff_cur, holdoff_new, count_rd;

  trigqual_sync u_trig_sync (
    .clk_usb (clk_usb),
    .reset_n (reset_n),
    .d       (trigger_i),
    .q       (ts)
  );

  assign cfg_sel     = (reg_address == `TRIGQUAL_CFG_ADDR);
  assign width_sel   = (reg_address == `TRIGQUAL_WIDTH_ADDR);
  assign holdoff_sel = (reg_address == `TRIGQUAL_HOLDOFF_ADDR);
  assign count_sel   = (reg_address == `TRIGQUAL_COUNT_ADDR);

  assign cfg_wr    = reg_write && cfg_sel;
  assign arm_wr    = cfg_wr && reg_datai[CFG_ARM_BIT];
  assign disarm_wr = cfg_wr && reg_datai[CFG_DISARM_BIT];
  assign mode_chg  = cfg_wr && (reg_datai[CFG_MODE_MSB:CFG_MODE_LSB] != mode_reg);

  // Target level is 1 for rising/high and 0 for falling/low; edge modes also need ts_d opposite.
  assign active = (ts == ~mode_reg[0]);
  assign start  = active && (mode_reg[1] || (ts != ts_d_reg));

  assign fire_take = (state_reg == ST_FIRE) && !disarm_wr;
  assign cnt_inc   = {1'b0, cnt_reg} + {{pCNT_WIDTH{1'b0}}, 1'b1};

  genvar gi;
  generate
    for (gi = 0; gi < TQ_REG_BYTES; gi++) begin : g_byte_we
      assign width_be[gi]   = reg_write && width_sel   && (reg_bytecnt == pBYTECNT_SIZE'(gi));
      assign holdoff_be[gi] = reg_write && holdoff_sel && (reg_bytecnt == pBYTECNT_SIZE'(gi));
    end
  endgenerate

  assign width_cur   = TQ_REG_W'(width_reg);
  assign holdoff_cur = TQ_REG_W'(holdoff_reg);

  always_comb begin
    width_new   = width_cur;
    holdoff_new = holdoff_cur;
    for (int b = 0; b < TQ_REG_BYTES; b++) begin
      if (width_be[b])   width_new[b*8 +: 8]   = reg_datai;
      if (holdoff_be[b]) holdoff_new[b*8 +: 8] = reg_datai;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    lim_next   = lim_reg;
    case (state_reg)
      ST_IDLE: begin
        if (arm_wr || arm_i) state_next = ST_ARMED;
      end
      ST_ARMED: begin
        if (start) begin
          if (width_reg <= CNT_ONE) begin
            state_next = ST_FIRE;
          end else begin
            cnt_next   = CNT_ONE;
            lim_next   = width_reg;
            state_next = ST_QUAL;
          end
        end
      end
      ST_QUAL: begin
        if (!active || mode_chg)                state_next = ST_ARMED;
        else if (cnt_inc >= {1'b0, lim_reg})    state_next = ST_FIRE;
        else                                    cnt_next   = cnt_inc[pCNT_WIDTH-1:0];
      end
      ST_FIRE: begin
        if (holdoff_reg != '0) begin
          cnt_next   = CNT_ONE;
          lim_next   = holdoff_reg;
          state_next = ST_HOLDOFF;
        end else begin
          state_next = oneshot_reg ? ST_IDLE : ST_ARMED;
        end
      end
      ST_HOLDOFF: begin
        if (cnt_reg >= lim_reg) state_next = oneshot_reg ? ST_IDLE : ST_ARMED;
        else                    cnt_next   = cnt_inc[pCNT_WIDTH-1:0];
      end
      default: state_next = ST_IDLE;
    endcase
    // Disarm overrides everything, including a pending FIRE.
    if (disarm_wr) state_next = ST_IDLE;
  end

  always_ff @(posedge clk_usb or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= ST_IDLE;
      cnt_reg        <= '0;
      lim_reg        <= '0;
      ts_d_reg       <= 1'b0;
      trig_pulse_reg <= 1'b0;
      armed_reg      <= 1'b0;
      busy_reg       <= 1'b0;
      mode_reg       <= MODE_RISE;
      oneshot_reg    <= 1'b1;
      width_reg      <= CNT_ONE;
      holdoff_reg    <= '0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      lim_reg        <= lim_next;
      ts_d_reg       <= ts;
      trig_pulse_reg <= fire_take;
      armed_reg      <= (state_next == ST_ARMED);
      busy_reg       <= (state_next == ST_QUAL) || (state_next == ST_FIRE) ||
                        (state_next == ST_HOLDOFF);
      if (cfg_wr) begin
        mode_reg    <= tq_mode_e'(reg_datai[CFG_MODE_MSB:CFG_MODE_LSB]);
        oneshot_reg <= reg_datai[CFG_ONESHOT_BIT];
      end
      width_reg   <= width_new[pCNT_WIDTH-1:0];
      holdoff_reg <= holdoff_new[pCNT_WIDTH-1:0];
    end
  end

`ifdef TRIGQUAL_COUNTER_EN
  logic [pCNT_WIDTH-1:0] count_reg;
  logic                  count_clr;

  assign count_clr = reg_write && count_sel;

  // A clear write beats a simultaneous fire; the count saturates at all-ones.
  always_ff @(posedge clk_usb or negedge reset_n) begin
    if (!reset_n)                          count_reg <= '0;
    else if (count_clr)                    count_reg <= '0;
    else if (fire_take && count_reg != '1) count_reg <= count_reg + CNT_ONE;
  end

  assign count_rd = TQ_REG_W'(count_reg);
`else
  assign count_rd = '0;
`endif

  always_comb begin
    reg_datao = 8'h00;
    if (reg_read) begin
      if (cfg_sel)          reg_datao = {3'b000, 1'b0, armed_reg, oneshot_reg, mode_reg};
      else if (width_sel)   reg_datao = byte_sel(width_cur, int'(reg_bytecnt));
      else if (holdoff_sel) reg_datao = byte_sel(holdoff_cur, int'(reg_bytecnt));
      else if (count_sel)   reg_datao = byte_sel(count_rd, int'(reg_bytecnt));
    end
  end

  assign trig_pulse_o = trig_pulse_reg;
  assign armed_o      = armed_reg;
  assign busy_o       = busy_reg;

endmodule

// File: tb/tb_trigger_qualifier.sv
// Directed + randomized bench for trigger_qualifier; expected pulse times and
// counts come from the latency/width/hold-off rules, not from the RTL.
module tb_trigger_qualifier;

  localparam logic [7:0] A_CFG     = 8'h50;
  localparam logic [7:0] A_WIDTH   = 8'h51;
  localparam logic [7:0] A_HOLDOFF = 8'h52;
  localparam logic [7:0] A_COUNT   = 8'h53;
`ifdef TRIGQUAL_COUNTER_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic       clk_usb = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] reg_address = 8'h00;
  logic [6:0] reg_bytecnt = 7'd0;
  logic [7:0] reg_datai = 8'h00;
  logic [7:0] reg_datao;
  logic       reg_read = 1'b0;
  logic       reg_write = 1'b0;
  logic       trigger_i = 1'b0;
  logic       arm_i = 1'b0;
  logic       trig_pulse_o, armed_o, busy_o;

  trigger_qualifier #(.pBYTECNT_SIZE(7), .pCNT_WIDTH(16)) dut (
    .clk_usb      (clk_usb),
    .reset_n      (reset_n),
    .reg_address  (reg_address),
    .reg_bytecnt  (reg_bytecnt),
    .reg_datai    (reg_datai),
    .reg_datao    (reg_datao),
    .reg_read     (reg_read),
    .reg_write    (reg_write),
    .trigger_i    (trigger_i),
    .arm_i        (arm_i),
    .trig_pulse_o (trig_pulse_o),
    .armed_o      (armed_o),
    .busy_o       (busy_o)
  );

  always #5 clk_usb = ~clk_usb;

  int cyc = 0;
  always @(posedge clk_usb) cyc <= cyc + 1;

  // Edge index at which each qualified pulse was seen high.
  int pulses[$];
  always @(negedge clk_usb) if (trig_pulse_o === 1'b1) pulses.push_back(cyc);

  int vectors = 0;
  int miscompares = 0;
  int exp_count = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk_usb);
  endtask

  task automatic wr(input logic [7:0] a, input logic [6:0] bc, input logic [7:0] d);
    reg_address = a; reg_bytecnt = bc; reg_datai = d; reg_write = 1'b1;
    @(negedge clk_usb);
    reg_write = 1'b0;
  endtask

  task automatic wr16(input logic [7:0] a, input logic [15:0] v);
    wr(a, 7'd0, v[7:0]);
    wr(a, 7'd1, v[15:8]);
  endtask

  task automatic rd16(input logic [7:0] a, output logic [15:0] v);
    reg_address = a; reg_read = 1'b1; reg_bytecnt = 7'd0;
    #1 v[7:0] = reg_datao;
    reg_bytecnt = 7'd1;
    #1 v[15:8] = reg_datao;
    reg_read = 1'b0;
  endtask

  // Trigger away from its idle level for n sampled cycles; s = first sampling edge.
  task automatic pulse(input logic idle, input int n, output int s);
    s = cyc + 1;
    trigger_i = ~idle;
    step(n);
    trigger_i = idle;
  endtask

  function automatic int eff_w(input int w);
    return (w < 1) ? 1 : w;
  endfunction

  function automatic int fire_at(input int s, input int w);
    return s + 2 + eff_w(w);
  endfunction

  function automatic int count_seen();
    return CNT_EN ? exp_count : 0;
  endfunction

  task automatic bump();
    if (exp_count < 65535) exp_count++;
  endtask

  task automatic expect_pulses(input string tag, input int n, input int first);
    check({tag, "_npulse"}, pulses.size(), n);
    if (n > 0 && pulses.size() > 0) check({tag, "_tpulse"}, pulses[0], first);
    pulses.delete();
  endtask

  task automatic check_count(input string tag);
    logic [15:0] v;
    rd16(A_COUNT, v);
    check(tag, v, count_seen());
  endtask

  initial begin
    logic [15:0] v;
    logic [1:0]  m;
    logic        idle;
    int s, s2, p1, w, n, c;

    // Reset state
    step(2);
    check("rst_pulse", trig_pulse_o, 0);
    check("rst_armed", armed_o, 0);
    check("rst_busy", busy_o, 0);
    reset_n = 1'b1;
    step(2);
    rd16(A_CFG, v);     check("rst_cfg", v[7:0], 8'h04);
    rd16(A_WIDTH, v);   check("rst_width", v, 1);
    rd16(A_HOLDOFF, v); check("rst_holdoff", v, 0);
    check_count("rst_count");
    reg_address = A_CFG; reg_read = 1'b0;
    #1 check("read_idle_zero", reg_datao, 0);

    // Rising edge, W=1, H=0, continuous
    step(1);
    wr(A_CFG, 7'd0, 8'h08);
    check("rise_armed", armed_o, 1);
    pulse(1'b0, 4, s);
    step(10);
    expect_pulses("rise", 1, fire_at(s, 1));
    bump();
    check("rise_rearmed", armed_o, 1);
    check_count("rise_count");

    // Glitch rejection in high-level mode
    wr16(A_WIDTH, 16'd10);
    wr(A_CFG, 7'd0, 8'h0A);
    step(4);
    pulse(1'b0, 6, s);
    step(20);
    expect_pulses("glitch_short", 0, 0);
    pulse(1'b0, 12, s);
    step(20);
    expect_pulses("glitch_long", 1, fire_at(s, 10));
    bump();
    check_count("glitch_count");

    // Randomized mode / width / pulse length, hold-off long enough to block re-fire
    for (int it = 0; it < 10; it++) begin
      m    = 2'($urandom_range(0, 3));
      w    = int'($urandom_range(0, 12));
      n    = int'($urandom_range(1, 16));
      idle = m[0];
      wr(A_CFG, 7'd0, 8'h10);
      trigger_i = idle;
      wr16(A_WIDTH, 16'(w));
      wr16(A_HOLDOFF, 16'd40);
      step(4);
      wr(A_CFG, 7'd0, {6'b000010, m});
      rd16(A_CFG, v);
      check("rnd_cfg", v[7:0], {6'b000010, m});
      pulse(idle, n, s);
      step(60);
      if (n >= eff_w(w)) begin
        expect_pulses($sformatf("rnd%0d_m%0d_w%0d_n%0d", it, m, w, n), 1, fire_at(s, w));
        bump();
      end else begin
        expect_pulses($sformatf("rnd%0d_m%0d_w%0d_n%0d", it, m, w, n), 0, 0);
      end
      check_count("rnd_count");
    end

    // Hold-off: H=100, edges 50 and 150 cycles after the first pulse
    wr(A_CFG, 7'd0, 8'h10);
    trigger_i = 1'b0;
    wr16(A_WIDTH, 16'd1);
    wr16(A_HOLDOFF, 16'd100);
    wr(A_COUNT, 7'd0, 8'h00);
    exp_count = 0;
    wr(A_CFG, 7'd0, 8'h08);
    step(3);
    pulse(1'b0, 3, s);
    p1 = fire_at(s, 1);
    while (cyc < p1 + 50) step(1);
    check("hold_busy", busy_o, 1);
    pulse(1'b0, 3, s2);
    while (cyc < p1 + 150) step(1);
    pulse(1'b0, 3, s2);
    step(10);
    check("hold_npulse", pulses.size(), 2);
    if (pulses.size() == 2) begin
      check("hold_t0", pulses[0], p1);
      check("hold_t1", pulses[1], fire_at(s2, 1));
    end
    pulses.delete();
    bump(); bump();
    check_count("hold_count");

    // One-shot with arm_i low
    wr16(A_HOLDOFF, 16'd0);
    wr(A_CFG, 7'd0, 8'h10);
    wr(A_CFG, 7'd0, 8'h0C);
    step(3);
    pulse(1'b0, 3, s);
    step(10);
    pulse(1'b0, 3, s2);
    step(10);
    expect_pulses("oneshot", 1, fire_at(s, 1));
    bump();
    check("oneshot_disarmed", armed_o, 0);
    wr(A_CFG, 7'd0, 8'h0C);
    check("oneshot_rearm", armed_o, 1);

    // Disarm write on the FIRE cycle
    wr(A_CFG, 7'd0, 8'h08);
    step(3);
    c = cyc;
    trigger_i = 1'b1;
    step(3);
    wr(A_CFG, 7'd0, 8'h10);
    step(5);
    trigger_i = 1'b0;
    expect_pulses("disarm_fire", 0, 0);
    check("disarm_armed", armed_o, 0);
    check("disarm_busy", busy_o, 0);
    check_count("disarm_count");

    // Count clear on the FIRE cycle
    wr(A_CFG, 7'd0, 8'h08);
    step(3);
    c = cyc;
    trigger_i = 1'b1;
    step(3);
    wr(A_COUNT, 7'd0, 8'h00);
    step(5);
    trigger_i = 1'b0;
    expect_pulses("clear_fire", 1, c + 4);
    exp_count = 0;
    check_count("clear_count");

    // Reset during QUAL
    wr16(A_WIDTH, 16'd20);
    wr(A_CFG, 7'd0, 8'h0A);
    step(3);
    trigger_i = 1'b1;
    step(8);
    check("qual_busy", busy_o, 1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_pulse", trig_pulse_o, 0);
    check("mid_rst_armed", armed_o, 0);
    check("mid_rst_busy", busy_o, 0);
    exp_count = 0;
    step(2);
    reset_n = 1'b1;
    step(3);
    check("post_rst_armed", armed_o, 0);
    rd16(A_CFG, v);     check("post_rst_cfg", v[7:0], 8'h04);
    rd16(A_WIDTH, v);   check("post_rst_width", v, 1);
    rd16(A_HOLDOFF, v); check("post_rst_holdoff", v, 0);
    check_count("post_rst_count");
    trigger_i = 1'b0;
    step(3);
    pulses.delete();

    // arm_i level with one-shot re-arms after each event
    arm_i = 1'b1;
    step(3);
    check("armi_armed", armed_o, 1);
    pulse(1'b0, 3, s);
    step(10);
    pulse(1'b0, 3, s2);
    step(10);
    check("armi_npulse", pulses.size(), 2);
    if (pulses.size() == 2) check("armi_t1", pulses[1], fire_at(s2, 1));
    pulses.delete();
    bump(); bump();
    check_count("armi_count");
    arm_i = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
